// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// sdram_arb_pkg : shared types and defaults for the SDRAM port arbiter
// Rev 1.0
// ============================================================================
package sdram_arb_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMD  = 1'b1
    } state_t;

    typedef logic [0:0] req_id_t;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// sdram_arb_tag_fifo : 1-bit tag FIFO recording the issuer of each read
// Rev 1.0
// ============================================================================
module sdram_arb_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_port_arbiter : round-robin two-master arbiter for one SDRAM ctrl port
// Rev 1.0
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = SDRAM_ADDR_W,
    parameter int DATA_W    = SDRAM_DATA_W,
    parameter int MAX_OUTST = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s0_address,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W-1:0]   s0_writedata,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    output logic                s0_waitrequest,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_readdatavalid,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                busy,
    output logic                err_underflow
);

    state_t  r_state;
    state_t  w_state_nxt;
    req_id_t r_grant;
    req_id_t w_grant_nxt;
    req_id_t r_rr_last;
    req_id_t w_rr_last_nxt;
    req_id_t w_tag_dout;
    logic    r_err_underflow;
    logic    w_req0;
    logic    w_req1;
    logic    w_g_read;
    logic    w_g_write;
    logic    w_accept;
    logic    w_push;
    logic    w_pop;
    logic    w_tag_full;
    logic    w_tag_empty;

    assign w_req0    = s0_read | s0_write;
    assign w_req1    = s1_read | s1_write;
    assign w_g_read  = (r_grant == 1'b1) ? s1_read  : s0_read;
    assign w_g_write = (r_grant == 1'b1) ? s1_write : s0_write;

    assign m_address    = (r_grant == 1'b1) ? s1_address    : s0_address;
    assign m_writedata  = (r_grant == 1'b1) ? s1_writedata  : s0_writedata;
    assign m_byteenable = (r_grant == 1'b1) ? s1_byteenable : s0_byteenable;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_last_nxt = r_rr_last;
        m_read        = 1'b0;
        m_write       = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_state_nxt = ST_CMD;
                    // Prefer the requester that did not win last time.
                    if (r_rr_last == 1'b1) begin
                        w_grant_nxt = w_req0 ? 1'b0 : 1'b1;
                    end else begin
                        w_grant_nxt = w_req1 ? 1'b1 : 1'b0;
                    end
                end
            end
            ST_CMD: begin
                m_write  = w_g_write;
                m_read   = w_g_read & ~w_g_write & ~w_tag_full;
                w_accept = (m_read | m_write) & ~m_waitrequest;
                if (w_accept) begin
                    w_rr_last_nxt = r_grant;
                    w_state_nxt   = ST_IDLE;
                end else if (!w_g_read && !w_g_write) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_grant         <= 1'b0;
            r_rr_last       <= 1'b1;
            r_err_underflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_last <= w_rr_last_nxt;
            if (m_readdatavalid && w_tag_empty) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign s0_waitrequest = ~(w_accept & (r_grant == 1'b0));
    assign s1_waitrequest = ~(w_accept & (r_grant == 1'b1));

    assign w_push = w_accept & m_read;
    assign w_pop  = m_readdatavalid & ~w_tag_empty;

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_grant),
        .dout  (w_tag_dout),
        .full  (w_tag_full),
        .empty (w_tag_empty)
    );

    // Return data is broadcast; only the valid strobe is routed by tag.
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = w_pop & (w_tag_dout == 1'b0);
    assign s1_readdatavalid = w_pop & (w_tag_dout == 1'b1);

    assign busy          = (r_state == ST_CMD) | ~w_tag_empty;
    assign err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sdram_port_arbiter : directed + randomized bench with a transaction model
// Rev 1.0
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int ADDR_W    = 25;
    localparam int DATA_W    = 16;
    localparam int BE_W      = DATA_W / 8;
    localparam int MAX_OUTST = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] s0_address, s1_address, m_address;
    logic              s0_read, s0_write, s1_read, s1_write;
    logic [DATA_W-1:0] s0_writedata, s1_writedata, m_writedata;
    logic [BE_W-1:0]   s0_byteenable, s1_byteenable, m_byteenable;
    logic              s0_waitrequest, s1_waitrequest;
    logic [DATA_W-1:0] s0_readdata, s1_readdata, m_readdata;
    logic              s0_readdatavalid, s1_readdatavalid;
    logic              m_read, m_write, m_waitrequest, m_readdatavalid;
    logic              busy, err_underflow;

    sdram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s0_address       (s0_address),
        .s0_read          (s0_read),
        .s0_write         (s0_write),
        .s0_writedata     (s0_writedata),
        .s0_byteenable    (s0_byteenable),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s1_address       (s1_address),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_writedata     (s1_writedata),
        .s1_byteenable    (s1_byteenable),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .m_address        (m_address),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_writedata      (m_writedata),
        .m_byteenable     (m_byteenable),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid),
        .busy             (busy),
        .err_underflow    (err_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: who holds the port, who won last, issued-read order.
    bit mdl_cmd, mdl_grant, mdl_last, mdl_err;
    int tagq[$];
    bit acc0, acc1;
    bit ctrl_auto = 1'b0;
    bit act[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_cmd = 1'b0; mdl_grant = 1'b0; mdl_last = 1'b1; mdl_err = 1'b0;
        tagq.delete();
    endtask

    task automatic clear_req(input int i);
        if (i == 0) begin s0_read = 1'b0; s0_write = 1'b0; end
        else        begin s1_read = 1'b0; s1_write = 1'b0; end
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        if (i == 0) begin
            s0_read = rd; s0_write = wr; s0_address = a; s0_writedata = d; s0_byteenable = be;
        end else begin
            s1_read = rd; s1_write = wr; s1_address = a; s1_writedata = d; s1_byteenable = be;
        end
    endtask

    // One clock: inputs already driven at the falling edge; check, then advance the model.
    task automatic step();
        bit req0, req1, gr, gw, e_rd, e_wr, acc, e_v0, e_v1, other;
        if (ctrl_auto) begin
            m_waitrequest   = ($urandom_range(3) == 0);
            m_readdatavalid = (tagq.size() > 0) && ($urandom_range(2) == 0);
            m_readdata      = DATA_W'($urandom);
        end
        #1;
        req0 = s0_read | s0_write;
        req1 = s1_read | s1_write;
        gr = 0; gw = 0; e_rd = 0; e_wr = 0; acc = 0; e_v0 = 0; e_v1 = 0;
        acc0 = 0; acc1 = 0;
        if (mdl_cmd) begin
            gr   = mdl_grant ? s1_read  : s0_read;
            gw   = mdl_grant ? s1_write : s0_write;
            e_wr = gw;
            e_rd = gr && !gw && (tagq.size() < MAX_OUTST);
            acc  = (e_rd || e_wr) && !m_waitrequest;
        end
        if (m_readdatavalid && tagq.size() > 0) begin
            if (tagq[0] == 0) e_v0 = 1; else e_v1 = 1;
        end
        chk("m_read", m_read, e_rd);
        chk("m_write", m_write, e_wr);
        chk("s0_waitrequest", s0_waitrequest, !(acc && mdl_grant == 0));
        chk("s1_waitrequest", s1_waitrequest, !(acc && mdl_grant == 1));
        chk("s0_readdatavalid", s0_readdatavalid, e_v0);
        chk("s1_readdatavalid", s1_readdatavalid, e_v1);
        chk("s0_readdata", s0_readdata, m_readdata);
        chk("s1_readdata", s1_readdata, m_readdata);
        chk("busy", busy, mdl_cmd || tagq.size() > 0);
        chk("err_underflow", err_underflow, mdl_err);
        if (e_rd || e_wr) begin
            chk("m_address", m_address, mdl_grant ? s1_address : s0_address);
            chk("m_writedata", m_writedata, mdl_grant ? s1_writedata : s0_writedata);
            chk("m_byteenable", m_byteenable, mdl_grant ? s1_byteenable : s0_byteenable);
        end
        if (m_readdatavalid) begin
            if (tagq.size() > 0) void'(tagq.pop_front());
            else mdl_err = 1;
        end
        if (!mdl_cmd) begin
            if (req0 || req1) begin
                other     = !mdl_last;
                mdl_grant = (other ? req1 : req0) ? other : mdl_last;
                mdl_cmd   = 1;
            end
        end else if (acc) begin
            if (e_rd) tagq.push_back(int'(mdl_grant));
            acc0 = (mdl_grant == 0);
            acc1 = (mdl_grant == 1);
            mdl_last = mdl_grant;
            mdl_cmd  = 0;
        end else if (!gr && !gw) begin
            mdl_cmd = 0;
        end
        @(negedge clk);
    endtask

    // Hold a command on requester i until it is accepted (bounded).
    task automatic issue(input int i, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        bit done = 0;
        set_req(i, !wr, wr, a, d, 2'b11);
        for (int n = 0; n < 40 && !done; n++) begin
            step();
            done = (i == 0) ? acc0 : acc1;
        end
        clear_req(i);
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL issue_timeout: observed accepted=%0d expected 1", done);
        end
    endtask

    task automatic drain();
        m_readdatavalid = 1'b1;
        for (int n = 0; n < 2 * MAX_OUTST && tagq.size() > 0; n++) begin
            m_readdata = DATA_W'($urandom);
            step();
        end
        m_readdatavalid = 1'b0;
    endtask

    task automatic rand_cmd(input int i);
        int k = $urandom_range(15);
        set_req(i, (k < 9) || (k == 15), k >= 9, ADDR_W'($urandom), DATA_W'($urandom),
                BE_W'($urandom));
        act[i] = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        s0_address = '0; s0_writedata = '0; s0_byteenable = '0;
        s1_address = '0; s1_writedata = '0; s1_byteenable = '0;
        clear_req(0); clear_req(1);
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
        mdl_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_s0_wait", s0_waitrequest, 1);
        chk("rst_s1_wait", s1_waitrequest, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_underflow, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single write from s0.
        issue(0, 1'b1, 25'h0000123, 16'hBEEF);
        step();

        // Routing of returns: s1, s0, s1 reads.
        issue(1, 1'b0, 25'h0000A00, '0);
        issue(0, 1'b0, 25'h0000B00, '0);
        issue(1, 1'b0, 25'h0000C00, '0);
        for (int n = 0; n < 3; n++) begin
            step();
            m_readdatavalid = 1'b1;
            m_readdata      = (n == 0) ? 16'h1111 : (n == 1) ? 16'h2222 : 16'h3333;
            step();
            m_readdatavalid = 1'b0;
        end

        // Outstanding limit: fill the tag FIFO, then hold a ninth read.
        for (int n = 0; n < MAX_OUTST; n++) issue(0, 1'b0, ADDR_W'(n), '0);
        s0_read = 1'b1; s0_address = 25'h1FF0000;
        repeat (6) step();
        chk("limit_hold_m_read", m_read, 0);
        chk("limit_hold_wait", s0_waitrequest, 1);
        m_readdatavalid = 1'b1; m_readdata = 16'h5A5A;
        step();
        m_readdatavalid = 1'b0;
        issue(0, 1'b0, 25'h1FF0000, '0);
        drain();

        // Stall hold: s1 write stalled by controller, s0 waits its turn.
        m_waitrequest = 1'b1;
        set_req(1, 1'b0, 1'b1, 25'h0ABCDEF, 16'hCAFE, 2'b01);
        s0_read = 1'b1; s0_address = 25'h0000777;
        repeat (6) step();
        m_waitrequest = 1'b0;
        issue(1, 1'b1, 25'h0ABCDEF, 16'hCAFE);
        issue(0, 1'b0, 25'h0000777, '0);
        drain();

        // Randomized traffic with a randomly stalling, randomly returning controller.
        ctrl_auto = 1'b1;
        act[0] = 1'b0; act[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && $urandom_range(2) == 0) rand_cmd(i);
                else if (act[i] && $urandom_range(63) == 0) begin
                    clear_req(i); act[i] = 1'b0;
                end
            end
            step();
            if (acc0) begin clear_req(0); act[0] = 1'b0; end
            if (acc1) begin clear_req(1); act[1] = 1'b0; end
        end
        ctrl_auto = 1'b0;
        clear_req(0); clear_req(1);
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
        repeat (2) step();
        drain();

        // Underflow: return data with nothing outstanding.
        m_readdatavalid = 1'b1; m_readdata = 16'hDEAD;
        step();
        m_readdatavalid = 1'b0;
        step();
        chk("underflow_sticky", err_underflow, 1);

        // Reset mid-CMD with three reads outstanding.
        for (int n = 0; n < 3; n++) issue(0, 1'b0, ADDR_W'(n + 16), '0);
        s1_read = 1'b1; m_waitrequest = 1'b1;
        step();
        chk("pre_reset_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_m_read", m_read, 0);
        chk("mid_rst_m_write", m_write, 0);
        chk("mid_rst_s0_wait", s0_waitrequest, 1);
        chk("mid_rst_s1_wait", s1_waitrequest, 1);
        chk("mid_rst_s0_rdv", s0_readdatavalid, 0);
        chk("mid_rst_s1_rdv", s1_readdatavalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_underflow, 0);
        @(negedge clk);
        clear_req(1); m_waitrequest = 1'b0;
        reset = 1'b0;
        mdl_reset();
        issue(1, 1'b0, 25'h0000042, '0);
        drain();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester Avalon-MM arbiter sharing one port of the on-chip SDRAM controller (16-bit external SDRAM, 25-bit word address) between the Nios data master path and a hardware accelerator master.
- Round-robin command arbitration with pipelined reads. An internal tag FIFO routes each returning read word to the requester that issued it.
- Sits between the two masters and the SDRAM controller's Avalon slave, inside the platform system.

Parameters:
ADDR_W, 25, word address width of the SDRAM controller slave
DATA_W, 16, data width; byteenable width is DATA_W/8
MAX_OUTST, 8, maximum outstanding reads; power of two, ≥2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s0_address  in  ADDR_W  requester 0 word address
s0_read  in  1  requester 0 read request
s0_write  in  1  requester 0 write request
s0_writedata  in  DATA_W  requester 0 write data
s0_byteenable  in  DATA_W/8  requester 0 byte enables
s0_waitrequest  out  1  requester 0 command stall
s0_readdata  out  DATA_W  read data (shared bus)
s0_readdatavalid  out  1  read data valid for requester 0
s1_*  (same eight signals as s0_*)  requester 1
m_address  out  ADDR_W  to SDRAM controller
m_read  out  1  to SDRAM controller
m_write  out  1  to SDRAM controller
m_writedata  out  DATA_W  to SDRAM controller
m_byteenable  out  DATA_W/8  to SDRAM controller
m_waitrequest  in  1  controller stall
m_readdata  in  DATA_W  controller read data
m_readdatavalid  in  1  controller read valid
busy  out  1  high when state=CMD or reads are outstanding
err_underflow  out  1  sticky; read data arrived with no tag

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_last=1 (requester 0 wins first), tag FIFO empty, err_underflow=0.
  - Outputs: m_read=m_write=0, s*_readdatavalid=0, s*_waitrequest=1, busy=0.
  - Reset mid-operation discards in-flight reads; the controller is reset by the same signal.
- req_i = s_i_read | s_i_write.
- FSM IDLE:
  - No req: stay.
  - Any req: the registered grant g takes the requester other than rr_last if it requests, else the sole requester. Go to CMD.
  - m_read/m_write are 0 in IDLE.
- FSM CMD:
  - m_address, m_writedata and m_byteenable are muxed combinationally from requester g.
  - m_write = s_g_write.
  - m_read = s_g_read & ~s_g_write & ~tag_full.
  - Read and write both high is illegal; write wins.
- Acceptance: (m_read|m_write) & ~m_waitrequest in CMD.
  - s_g_waitrequest=0 in exactly that cycle.
  - If a read, push g into the tag FIFO.
  - rr_last<=g; next state IDLE.
  - Result: one-cycle bubble, at most one command per 2 cycles.
- s_i_waitrequest=1 in every other cycle, including for the non-granted requester and while tag_full blocks a read.
- Requester g drops both read and write in CMD (protocol violation): return to IDLE, no command issued, rr_last unchanged.
- Read return:
  - On m_readdatavalid, pop the FIFO. s_t_readdatavalid=1 in the same cycle (zero latency) for tag t.
  - s0_readdata = s1_readdata = m_readdata at all times.
  - readdatavalid with the FIFO empty: both s*_readdatavalid=0, data dropped, err_underflow<=1 until reset.
- Tag FIFO push blocking: push is blocked whenever full, even with a simultaneous pop (conservative). Reads are held until a slot frees.
- Simultaneous push and pop when not full: count unchanged, pointers both advance.
- Pointers wrap modulo MAX_OUTST. Count width is clog2(MAX_OUTST)+1.
- busy = (state==CMD) | ~tag_empty.

Decomposition:
- Package sdram_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - State enum {IDLE, CMD}.
  - Requester-id typedef (1 bit).
- One sub-module, sdram_arb_tag_fifo:
  - 1-bit-wide synchronous FIFO, depth MAX_OUTST.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-high reset.
- Top level holds the FSM, round-robin pointer, command mux and return routing.

Test Plan:
- Single write: s0 writes addr 0x0000123, data 0xBEEF, be 2'b11, m_waitrequest=0 → m_write pulses with the same fields one cycle after request; s0_waitrequest low that cycle only.
- Contention fairness: s0 and s1 both issue continuous reads, controller never stalls → grants alternate 0,1,0,1; each accepted every 4 cycles; returned data tagged in order.
- Out-of-order-free routing: s1 read A, s0 read B, s1 read C; controller returns 0x1111, 0x2222, 0x3333 with 3-cycle latency → s1_readdatavalid for 0x1111 and 0x3333, s0_readdatavalid for 0x2222.
- Outstanding limit: MAX_OUTST=8, 8 reads accepted, none returned → 9th read held (m_read=0, s_waitrequest=1); first m_readdatavalid pop → 9th read issues on the next CMD cycle.
- Stall hold: m_waitrequest=1 for 5 cycles during s1 write → m_* stable; s0 request ignored meanwhile; s1 completes, then s0 granted.
- Underflow and reset: m_readdatavalid with empty FIFO → err_underflow=1, no s*_readdatavalid. Then assert reset mid-CMD with 3 reads outstanding → all outputs reach reset values immediately, busy=0, err_underflow=0.
